counter_controller: RTL
=======================

# counter_controller

Run controller for the team's 4-bit counter datapath. It sequences one counting run: captures start value, terminal value, direction and wrap mode on a start request, loads the counter, advances it on each step, flags terminal count, and either stops or reloads. It replaces free-running ripple counting with a handshake-driven, synchronous, abortable run that other blocks can start and poll.

## Interface
- WIDTH, 4, counter width in bits
- clock  in  1  single clock; all state updates on rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  run request; accepted only in IDLE
- init  in  WIDTH  start value, sampled with accepted start
- limit  in  WIDTH  terminal value, sampled with accepted start
- up  in  1  direction (1 = increment, 0 = decrement), sampled with accepted start
- wrap  in  1  1 = reload init after terminal and continue; 0 = stop; sampled with accepted start
- step  in  1  count enable in RUN; low = pause/hold
- stop  in  1  abort request, honoured in LOAD and RUN
- count  out  WIDTH  current counter value
- busy  out  1  high in LOAD and RUN
- done  out  1  high for exactly the one cycle in DONE
- tc  out  1  registered one-cycle terminal-count pulse
- aborted  out  1  run ended by stop; held until next accepted start

## Operation
- States: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11.
- IDLE: count holds. start=1 → capture init/limit/up/wrap into shadow registers, clear aborted, go to LOAD.
- LOAD: count ← init_r; go to RUN. stop=1 → DONE, aborted ← 1, count unchanged.
- RUN, priority order:
  - stop=1 → DONE, aborted ← 1, count holds, no tc (stop beats terminal step).
  - step=0 → hold.
  - step=1 and count==limit_r → tc ← 1; wrap_r=1: count ← init_r, stay RUN; wrap_r=0: count holds, go to DONE.
  - step=1 otherwise → count ← count ± 1, modulo 2^WIDTH (15+1=0, 0−1=15).
- DONE → IDLE unconditionally.
- init==limit: first step in RUN is terminal.
- Distance is modular: up with limit < init passes through wrap-around (init=14, limit=1 up: 14,15,0,1).
- start outside IDLE is ignored, not queued. Input changes after capture do not affect the run.
- With wrap_r=1 the run ends only via stop.

## Timing
- clear=1: immediately, independent of clock: state IDLE, count 0, busy 0, done 0, tc 0, aborted 0, shadow registers 0. Mid-run clear discards the run; no done.
- busy and done are Moore outputs decoded from state.
- tc is high in the cycle after the terminal step edge, coincident with DONE (no wrap) or with count==init_r (wrap).
- With start accepted at edge 0 and step held high: LOAD after edge 0, count=init after edge 1, first change at edge 2, terminal step at edge d+2 with d=(limit−init) mod 2^WIDTH (up) or (init−limit) mod 2^WIDTH (down); done high for one cycle after edge d+2; IDLE after edge d+3.
- Earliest next accepted start: the cycle done is high is still DONE, so start is sampled at the following IDLE cycle.

## Structure
- Package counter_controller_pkg: state enum (IDLE/LOAD/RUN/DONE with the encodings above), WIDTH default 4.
- Sub-module updown_counter: WIDTH-bit register with async clear, synchronous load, enable and up/down inputs. Controller holds the FSM, shadow registers, tc/aborted flags and the limit comparator.

## Test plan
- Up run, no wrap: init=3, limit=6, up=1, step high → count 3,4,5,6; tc and done high together 5 cycles after start edge; aborted=0; back to IDLE with count=6.
- Down through wrap-around: init=1, limit=14, up=0 → count 1,0,15,14; done 5 cycles after start.
- Wrap mode plus stop: init=2, limit=4, wrap=1 → 2,3,4,2,3,4 with tc at each reload; stop while count=3 → done, aborted=1, no tc, count=3.
- Pause and edges: step low for 3 cycles mid-run → count holds, busy stays 1. init==limit=9 → tc and done after the first step. start during RUN → ignored.
- Collision and reset: stop and terminal step in the same cycle → aborted=1, tc=0. clear pulse between clock edges mid-run → all outputs 0 immediately, state IDLE, a fresh start works.

Source files
------------

// File: rtl/counter_controller_pkg.sv
// Shared types and defaults for the counter run controller and its counter datapath.
package counter_controller_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/updown_counter.sv
// W-bit up/down counter with async clear, synchronous load and count enable.
// Load has priority over enable; counting is modulo 2^W.
module updown_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // next counter value
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = up_i ? (q_q + ONE) : (q_q - ONE);
    end else begin
      q_d = q_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/counter_controller.sv
// Run controller: captures a run on start, loads and steps the counter,
// flags terminal count, then stops or reloads; a run can be aborted by stop.
module counter_controller
  import counter_controller_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             wrap,
  input  logic             step,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             aborted
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             up_q, up_d;
  logic             wrap_q, wrap_d;
  logic             tc_q, tc_d;
  logic             aborted_q, aborted_d;

  logic             cnt_load_s;
  logic             cnt_en_s;
  logic [WIDTH-1:0] cnt_s;
  logic             at_limit_s;

  assign at_limit_s = (cnt_s == limit_q);

  // next state, shadow capture, flags and counter controls
  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    limit_d    = limit_q;
    up_d       = up_q;
    wrap_d     = wrap_q;
    tc_d       = 1'b0;
    aborted_d  = aborted_q;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          init_d    = init;
          limit_d   = limit;
          up_d      = up;
          wrap_d    = wrap;
          aborted_d = 1'b0;
          state_d   = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_load_s = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // stop wins over a coincident terminal step
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (!step) begin
          state_d = RUN;
        end else if (at_limit_s) begin
          tc_d = 1'b1;
          if (wrap_q) begin
            cnt_load_s = 1'b1;
            state_d    = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_en_s = 1'b1;
          state_d  = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, shadow registers and status flags
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      init_q    <= '0;
      limit_q   <= '0;
      up_q      <= 1'b0;
      wrap_q    <= 1'b0;
      tc_q      <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      limit_q   <= limit_d;
      up_q      <= up_d;
      wrap_q    <= wrap_d;
      tc_q      <= tc_d;
      aborted_q <= aborted_d;
    end
  end

  updown_counter #(
    .W(WIDTH)
  ) u_counter (
    .clk_i      (clock),
    .clr_i      (clear),
    .load_i     (cnt_load_s),
    .load_val_i (init_q),
    .en_i       (cnt_en_s),
    .up_i       (up_q),
    .q_o        (cnt_s)
  );

  assign count   = cnt_s;
  assign busy    = (state_q == LOAD) || (state_q == RUN);
  assign done    = (state_q == DONE);
  assign tc      = tc_q;
  assign aborted = aborted_q;

endmodule
